// File: rtl/ui_pkg.sv
// Shared types and defaults for the peripheral TX path.
// Holds the arbiter state encoding, the ID field position and
// the default peripheral count / burst length used by the FIFOs
// and the top level.
package ui_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // MSB of the source-ID field stamped into each outgoing word.
    localparam int PKT_ID_MSB = 31;

    localparam int WORD_W = 32;

    localparam int DEF_NUM_PERIPH = 8;
    localparam int DEF_MAX_BURST  = 16;

endpackage

// File: rtl/rr_picker.sv
// Round-robin requester picker (purely combinational).
// Ports: req   - request vector, one bit per requester
//        last  - index served most recently
//        found - at least one request is pending
//        next  - first requester after last, modulo N
module rr_picker #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] next
);

    logic [N-1:0]  rot;
    logic [IW-1:0] offs;

    // Rotate so that bit 0 is the requester right after last;
    // N is a power of two, so IW-bit addition wraps for free.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[last + IW'(i) + IW'(1)];
        end
    end

    // Lowest set bit of the rotated vector wins; un-rotate it.
    always_comb begin
        offs = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offs = IW'(i);
            end
        end
        found = |rot;
        next  = last + offs + IW'(1);
    end

endmodule

// File: rtl/periph_tx_arbiter.sv
// Shares the FT601 write path among NUM_PERIPH FWFT TX FIFOs.
// Round-robin grant, bursts of up to MAX_BURST words, each word
// stamped with its source index in bits [31:32-ID_W].
// Ports: clk, rst (async, active-high), enable (periph_ready),
//        fifo_empty / fifo_data (per-FIFO head), fifo_rd_en (pop),
//        out_data / out_valid / out_ready (stream to controller),
//        grant_id (current or last grant), busy (in GRANT).
module periph_tx_arbiter
    import ui_pkg::*;
#(
    parameter int NUM_PERIPH = DEF_NUM_PERIPH,
    parameter int ID_W       = $clog2(NUM_PERIPH),
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [NUM_PERIPH-1:0]        fifo_empty,
    input  logic [NUM_PERIPH*WORD_W-1:0] fifo_data,
    output logic [NUM_PERIPH-1:0]        fifo_rd_en,
    output logic [WORD_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    if (NUM_PERIPH < 2 || NUM_PERIPH > 8 ||
        (1 << ID_W) != NUM_PERIPH) begin : g_bad_num
        $error("NUM_PERIPH must be a power of 2 in 2..8");
    end

    if (MAX_BURST < 1) begin : g_bad_burst
        $error("MAX_BURST must be at least 1");
    end

    arb_state_t     state;
    logic [ID_W-1:0] last_id;
    logic [CW-1:0]   burst_cnt;

    logic            found;
    logic [ID_W-1:0] pick;

    logic [WORD_W-1:0] head;
    logic              head_empty;
    logic              in_grant;
    logic              pop;
    logic              leave;

    rr_picker #(
        .N  (NUM_PERIPH),
        .IW (ID_W)
    ) u_pick (
        .req   (~fifo_empty),
        .last  (last_id),
        .found (found),
        .next  (pick)
    );

    always_comb begin
        head = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (grant_id == ID_W'(i)) begin
                head = fifo_data[WORD_W*i +: WORD_W];
            end
        end
    end

    assign head_empty = fifo_empty[grant_id];
    assign in_grant   = (state == GRANT);
    assign busy       = in_grant;

    // Outputs follow state combinationally so that a reset or an
    // enable drop silences the stream in the same cycle.
    assign out_valid = in_grant & enable & ~head_empty;
    assign pop       = out_valid & out_ready;

    assign out_data = in_grant
        ? {grant_id, head[PKT_ID_MSB-ID_W:0]}
        : '0;

    always_comb begin
        fifo_rd_en = '0;
        if (pop) begin
            fifo_rd_en[grant_id] = 1'b1;
        end
    end

    // Burst limit, drained FIFO and enable drop all end the grant
    // the same way, so one flag covers them.
    assign leave = (pop && burst_cnt == LAST_BEAT) ||
                   head_empty || !enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= '0;
            last_id   <= ID_W'(NUM_PERIPH - 1);
            burst_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable && found) begin
                        grant_id  <= pick;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (pop) begin
                        burst_cnt <= burst_cnt + CW'(1);
                    end
                    if (leave) begin
                        last_id <= grant_id;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_tx_arbiter.sv
// Bench for periph_tx_arbiter: cycle table plus directed
// sequences for round-robin bursts, reset and MAX_BURST=1.
module tb_periph_tx_arbiter;

    localparam int N  = 8;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en0, en1, rdy0, rdy1, use1;
    logic [N-1:0]    fifo_empty;
    logic [N*32-1:0] fifo_data;

    logic [N-1:0]  rd0, rd1;
    logic [31:0]   d0, d1;
    logic          v0, v1, b0, b1;
    logic [IW-1:0] g0, g1;

    logic [N-1:0]  s_rd0, s_rd1;
    logic [31:0]   s_d0, s_d1;
    logic          s_v0, s_v1, s_b0, s_b1;
    logic [IW-1:0] s_g0, s_g1;

    int cnt[N];
    int seq[N];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    periph_tx_arbiter #(.NUM_PERIPH(N), .MAX_BURST(16)) dut (
        .clk(clk), .rst(rst), .enable(en0),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(rd0), .out_data(d0), .out_valid(v0),
        .out_ready(rdy0), .grant_id(g0), .busy(b0)
    );

    periph_tx_arbiter #(.NUM_PERIPH(N), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .enable(en1),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(rd1), .out_data(d1), .out_valid(v1),
        .out_ready(rdy1), .grant_id(g1), .busy(b1)
    );

    typedef struct {
        int         li;
        int         ln;
        logic       rdy;
        logic       en;
        logic       ev;
        logic [7:0] erd;
        logic       eb;
        int         eg;
        int         es;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int li, int ln, logic rdy,
        logic en, logic ev, logic [7:0] erd, logic eb,
        int eg, int es);
        vec_t v;
        v.li = li; v.ln = ln; v.rdy = rdy; v.en = en;
        v.ev = ev; v.erd = erd; v.eb = eb; v.eg = eg; v.es = es;
        return v;
    endfunction

    function automatic logic [31:0] word(int i, int s);
        logic [31:0] w;
        w = {4'hC, 4'(i), 8'(s), 16'h5A00 | 16'(i)};
        return w;
    endfunction

    function automatic logic [31:0] exp_word(int i, int s);
        logic [31:0] w;
        w = word(i, s);
        w[31:29] = 3'(i);
        return w;
    endfunction

    task automatic chk(string nm, logic [31:0] act,
        logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = (cnt[i] == 0);
            fifo_data[32*i +: 32] = word(i, seq[i]);
        end
    endtask

    task automatic load(int i, int n);
        cnt[i] += n;
        refresh();
    endtask

    // Sample outputs at negedge, then apply the sampled pops to the
    // FIFO model just after the following posedge.
    task automatic tick();
        logic p;
        @(negedge clk);
        s_rd0 = rd0; s_d0 = d0; s_v0 = v0; s_b0 = b0; s_g0 = g0;
        s_rd1 = rd1; s_d1 = d1; s_v1 = v1; s_b1 = b1; s_g1 = g1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            p = use1 ? s_rd1[i] : s_rd0[i];
            if (p && cnt[i] > 0) begin
                cnt[i]--;
                seq[i]++;
            end
        end
        refresh();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            seq[i] = 0;
        end
        refresh();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(string nm);
        int k;
        k = 0;
        while (k < 100 && !(fifo_empty == '1 && !s_b0)) begin
            tick();
            k++;
        end
        chk(nm, 32'(k < 100), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int gid_q[$], pops_q[$], busy_q[$], fp_q[$], lp_q[$];
        int pseq[N];
        int derr, last, idx;
        logic pb;
        int eid[9];
        int epop[9];
        int ebsy[9];

        use1 = 1'b0; en0 = 1'b0; en1 = 1'b0;
        rdy0 = 1'b0; rdy1 = 1'b0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            seq[i] = 0;
        end
        refresh();

        @(negedge clk);
        chk("rst valid", 32'(v0), 0);
        chk("rst rd_en", 32'(rd0), 0);
        chk("rst busy", 32'(b0), 0);
        chk("rst gid", 32'(g0), 0);
        chk("rst data", d0, 0);
        chk("rst valid1", 32'(v1), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester, ready stall, enable abort.
        tbl.push_back(mk(2, 3, 1, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 8'h04, 1, 2, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 8'h04, 1, 2, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, 8'h04, 1, 2, 2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00, 1, 2, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00, 0, 2, 0));
        tbl.push_back(mk(3, 2, 1, 1, 0, 8'h00, 0, 2, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 8'h08, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 8'h00, 1, 3, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 8'h00, 1, 3, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, 8'h08, 1, 3, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00, 1, 3, 0));
        tbl.push_back(mk(4, 10, 1, 1, 0, 8'h00, 0, 3, 0));
        tbl.push_back(mk(6, 3, 1, 1, 1, 8'h10, 1, 4, 0));
        for (int s = 1; s < 5; s++)
            tbl.push_back(mk(0, 0, 1, 1, 1, 8'h10, 1, 4, s));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 1, 4, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 0, 4, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00, 0, 4, 0));
        for (int s = 0; s < 3; s++)
            tbl.push_back(mk(0, 0, 1, 1, 1, 8'h40, 1, 6, s));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00, 1, 6, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00, 0, 6, 0));
        for (int s = 5; s < 10; s++)
            tbl.push_back(mk(0, 0, 1, 1, 1, 8'h10, 1, 4, s));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00, 1, 4, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'h00, 0, 4, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            v = tbl[k];
            if (v.ln > 0) load(v.li, v.ln);
            rdy0 = v.rdy;
            en0  = v.en;
            tick();
            chk($sformatf("t%0d valid", k), 32'(s_v0), 32'(v.ev));
            chk($sformatf("t%0d rd_en", k), 32'(s_rd0), 32'(v.erd));
            chk($sformatf("t%0d busy", k), 32'(s_b0), 32'(v.eb));
            chk($sformatf("t%0d gid", k), 32'(s_g0), 32'(v.eg));
            if (v.ev)
                chk($sformatf("t%0d data", k), s_d0,
                    exp_word(v.eg, v.es));
        end

        // Reset in the middle of a grant.
        load(5, 4);
        rdy0 = 1'b1;
        en0  = 1'b1;
        tick();
        chk("pre-grant valid", 32'(s_v0), 0);
        chk("grant valid", 32'(v0), 1);
        chk("grant rd_en", 32'(rd0), 32'h20);
        rst = 1'b1;
        #1;
        chk("async rst rd_en", 32'(rd0), 0);
        chk("async rst valid", 32'(v0), 0);
        chk("async rst busy", 32'(b0), 0);
        chk("async rst gid", 32'(g0), 0);
        load(1, 1);
        load(6, 1);
        tick();
        chk("rst hold rd_en", 32'(s_rd0), 0);
        rst = 1'b0;
        tick();
        chk("post rst idle", 32'(s_b0), 0);
        tick();
        chk("post rst gid", 32'(s_g0), 1);
        chk("post rst rd_en", 32'(s_rd0), 32'h02);
        chk("post rst data", s_d0, exp_word(1, 0));
        tick();
        tick();
        tick();
        chk("no partial pop gid", 32'(s_g0), 5);
        chk("no partial pop data", s_d0, exp_word(5, 0));
        drain("rst drain");

        // Round-robin bursts over FIFOs 0, 1, 5.
        do_reset();
        load(0, 40);
        load(1, 40);
        load(5, 40);
        rdy0 = 1'b1;
        en0  = 1'b1;
        derr = 0;
        pb   = 1'b0;
        for (int i = 0; i < N; i++) pseq[i] = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (s_b0 && !pb) begin
                gid_q.push_back(int'(s_g0));
                pops_q.push_back(0);
                busy_q.push_back(0);
                fp_q.push_back(-1);
                lp_q.push_back(-1);
            end
            last = gid_q.size() - 1;
            if (s_b0 && last >= 0) busy_q[last]++;
            if (s_rd0 != 0) begin
                if (last < 0) derr++;
                else begin
                    idx = int'(s_g0);
                    if (s_rd0 != (8'd1 << s_g0)) derr++;
                    if (s_d0 != exp_word(idx, pseq[idx])) derr++;
                    pseq[idx]++;
                    pops_q[last]++;
                    if (fp_q[last] < 0) fp_q[last] = c;
                    lp_q[last] = c;
                end
            end
            pb = s_b0;
            if (fifo_empty == '1 && !s_b0) break;
        end
        chk("rr drained", 32'(fifo_empty), 32'hFF);
        chk("rr data errs", derr, 0);
        chk("rr grants", gid_q.size(), 9);
        eid  = '{0, 1, 5, 0, 1, 5, 0, 1, 5};
        epop = '{16, 16, 16, 16, 16, 16, 8, 8, 8};
        ebsy = '{16, 16, 16, 16, 16, 16, 9, 9, 9};
        for (int k = 0; k < 9 && k < gid_q.size(); k++) begin
            chk($sformatf("rr%0d id", k), gid_q[k], eid[k]);
            chk($sformatf("rr%0d pops", k), pops_q[k], epop[k]);
            chk($sformatf("rr%0d busy", k), busy_q[k], ebsy[k]);
            if (k < 8 && k + 1 < gid_q.size())
                chk($sformatf("rr%0d gap", k), fp_q[k+1] - lp_q[k],
                    (k < 6) ? 2 : 3);
        end

        // MAX_BURST=1 with every FIFO non-empty.
        do_reset();
        use1 = 1'b1;
        en0  = 1'b0;
        en1  = 1'b1;
        rdy1 = 1'b1;
        for (int i = 0; i < N; i++) load(i, 2);
        for (int c = 0; c < 32; c++) begin
            tick();
            if (c % 2 == 1) begin
                idx = ((c % 16) - 1) / 2;
                chk($sformatf("mb1 c%0d rd_en", c), 32'(s_rd1),
                    32'(1) << idx);
                chk($sformatf("mb1 c%0d gid", c), 32'(s_g1), idx);
                chk($sformatf("mb1 c%0d data", c), s_d1,
                    exp_word(idx, c / 16));
            end else begin
                chk($sformatf("mb1 c%0d rd_en", c), 32'(s_rd1), 0);
                chk($sformatf("mb1 c%0d busy", c), 32'(s_b1), 0);
            end
        end
        chk("mb1 drained", 32'(fifo_empty), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
